// File: rtl/router_3_arbiter_if.sv
// Handshake bundle between the three input channels, flow control and the
// router 3 output-port arbiter.
interface router_3_arbiter_if;
    logic       Nreq;
    logic       Wreq;
    logic       Lreq;
    logic       Ntail;
    logic       Wtail;
    logic       Ltail;
    logic       ready;
    logic       Ngrant;
    logic       Wgrant;
    logic       Lgrant;
    logic [1:0] sel;
    logic       Nxfer;
    logic       Wxfer;
    logic       Lxfer;
    logic       busy;

    // The request/flow-control side drives reqs, tails and ready.
    modport master (
        output Nreq, Wreq, Lreq, Ntail, Wtail, Ltail, ready,
        input  Ngrant, Wgrant, Lgrant, sel, Nxfer, Wxfer, Lxfer, busy
    );

    modport slave (
        input  Nreq, Wreq, Lreq, Ntail, Wtail, Ltail, ready,
        output Ngrant, Wgrant, Lgrant, sel, Nxfer, Wxfer, Lxfer, busy
    );
endinterface

// File: rtl/router_3_arbiter.sv
// Router 3 output-port arbiter: round-robin over N/W/L, with the port locked
// from header to tail flit and re-arbitration in the tail cycle.
module router_3_arbiter #(
    parameter logic [1:0] RESET_PTR = 2'd0
) (
    input  logic               clk,
    input  logic               rst,
    router_3_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_N = 2'd1,
        GNT_W = 2'd2,
        GNT_L = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [2:0] req;
    logic [2:0] tail;
    logic [2:0] grant;
    logic [2:0] xfer;
    logic [2:0] win;
    logic       rearb;

    // Returns {found, port}; the first requester in pointer order wins.
    function automatic logic [2:0] arbitrate(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] idx;
        logic [2:0] result;
        result = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            idx = {1'b0, p} + 3'(i);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (r[idx[1:0]]) result = {1'b1, idx[1:0]};
        end
        return result;
    endfunction

    assign req  = {bus.Lreq, bus.Wreq, bus.Nreq};
    assign tail = {bus.Ltail, bus.Wtail, bus.Ntail};

    assign grant[0] = (state == GNT_N);
    assign grant[1] = (state == GNT_W);
    assign grant[2] = (state == GNT_L);
    assign xfer     = grant & req & {3{bus.ready}};

    assign bus.Ngrant = grant[0];
    assign bus.Wgrant = grant[1];
    assign bus.Lgrant = grant[2];
    assign bus.sel    = state;
    assign bus.busy   = (state != IDLE);
    assign bus.Nxfer  = xfer[0];
    assign bus.Wxfer  = xfer[1];
    assign bus.Lxfer  = xfer[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= RESET_PTR;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // The pointer is advanced at grant time, so a tail-cycle re-arbitration
    // already sees the finishing port last in search order.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        rearb     = (state == IDLE) || ((xfer & tail) != 3'b000);
        win       = arbitrate(req, ptr);
        if (rearb) begin
            if (win[2]) begin
                state_nxt = state_t'(win[1:0] + 2'd1);
                ptr_nxt   = (win[1:0] == 2'd2) ? 2'd0 : win[1:0] + 2'd1;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_router_3_arbiter.sv
// Self-checking bench for router_3_arbiter: directed packet scenarios with
// literal expectations, then random traffic against a packet-level model.
module tb_router_3_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Model: which port owns the output (-1 none) and the round-robin pointer.
    int   owner = -1;
    int   mptr  = 0;

    router_3_arbiter_if bus_if ();

    router_3_arbiter #(.RESET_PTR(2'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [2:0] req, input logic [2:0] tail, input logic rdy);
        bus_if.Nreq  = req[0];
        bus_if.Wreq  = req[1];
        bus_if.Lreq  = req[2];
        bus_if.Ntail = tail[0];
        bus_if.Wtail = tail[1];
        bus_if.Ltail = tail[2];
        bus_if.ready = rdy;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] expGrant, input logic [1:0] expSel,
                               input logic expBusy, input logic [2:0] expXfer);
        logic [2:0] g;
        logic [2:0] x;
        g = {bus_if.Lgrant, bus_if.Wgrant, bus_if.Ngrant};
        x = {bus_if.Lxfer, bus_if.Wxfer, bus_if.Nxfer};
        checks++;
        if (g !== expGrant || bus_if.sel !== expSel || bus_if.busy !== expBusy || x !== expXfer) begin
            errors++;
            $display("[TB] FAIL %s: got grant=%b sel=%b busy=%b xfer=%b, expected grant=%b sel=%b busy=%b xfer=%b",
                     name, g, bus_if.sel, bus_if.busy, x, expGrant, expSel, expBusy, expXfer);
        end
    endtask

    function automatic logic modelReq(input int p);
        case (p)
            0:       return bus_if.Nreq;
            1:       return bus_if.Wreq;
            default: return bus_if.Lreq;
        endcase
    endfunction

    function automatic logic modelTail(input int p);
        case (p)
            0:       return bus_if.Ntail;
            1:       return bus_if.Wtail;
            default: return bus_if.Ltail;
        endcase
    endfunction

    // Packet-level model: a free port goes to the first requester from the
    // pointer onward; the owner keeps it until its tail flit is accepted.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner = -1;
            mptr  = 0;
        end else begin
            if (owner >= 0 && modelReq(owner) && bus_if.ready && modelTail(owner))
                owner = -1;
            if (owner < 0) begin
                for (int k = 0; k < 3; k++) begin
                    if (owner < 0 && modelReq((mptr + k) % 3)) begin
                        owner = (mptr + k) % 3;
                    end
                end
                if (owner >= 0) mptr = (owner + 1) % 3;
            end
        end
    end

    // Compare every cycle against the model, away from the rising edge.
    always @(negedge clk) begin
        logic [2:0] eg;
        logic [2:0] ex;
        logic [1:0] es;
        logic [2:0] g;
        logic [2:0] x;
        eg = 3'b000;
        ex = 3'b000;
        es = 2'b00;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            es        = 2'(owner + 1);
            ex[owner] = modelReq(owner) & bus_if.ready;
        end
        g = {bus_if.Lgrant, bus_if.Wgrant, bus_if.Ngrant};
        x = {bus_if.Lxfer, bus_if.Wxfer, bus_if.Nxfer};
        checks++;
        if (g !== eg) begin
            errors++;
            $display("[TB] FAIL model_grant @%0t: got %b expected %b", $time, g, eg);
        end
        checks++;
        if (bus_if.sel !== es) begin
            errors++;
            $display("[TB] FAIL model_sel @%0t: got %b expected %b", $time, bus_if.sel, es);
        end
        checks++;
        if (bus_if.busy !== (owner >= 0)) begin
            errors++;
            $display("[TB] FAIL model_busy @%0t: got %b expected %b", $time, bus_if.busy, owner >= 0);
        end
        checks++;
        if (x !== ex) begin
            errors++;
            $display("[TB] FAIL model_xfer @%0t: got %b expected %b", $time, x, ex);
        end
    end

    logic [2:0] rrSeq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [1:0] rrSel [6] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};

    initial begin
        applyStimulus(3'b111, 3'b111, 1'b1);
        waitEdge();
        waitEdge();
        #2 checkOutput("reset_hold", 3'b000, 2'b00, 1'b0, 3'b000);

        // Release with all requesters and single-flit packets: pure round-robin.
        waitEdge();
        rst = 1'b1;
        #2 checkOutput("release_idle", 3'b000, 2'b00, 1'b0, 3'b000);
        for (int k = 0; k < 6; k++) begin
            waitEdge();
            #2 checkOutput("round_robin", rrSeq[k], rrSel[k], 1'b1, rrSeq[k]);
        end

        // Packet lock: N sends four flits while W waits.
        waitEdge();
        rst = 1'b0;
        applyStimulus(3'b011, 3'b000, 1'b1);
        #2 checkOutput("reset_mid", 3'b000, 2'b00, 1'b0, 3'b000);
        waitEdge();
        rst = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            waitEdge();
            if (f == 4) applyStimulus(3'b011, 3'b001, 1'b1);
            #2 checkOutput("lock_flit", 3'b001, 2'b01, 1'b1, 3'b001);
        end

        // W takes over with no bubble, then stalls on its tail.
        waitEdge();
        applyStimulus(3'b011, 3'b010, 1'b0);
        #2 checkOutput("lock_next_w", 3'b010, 2'b10, 1'b1, 3'b000);
        for (int s = 0; s < 2; s++) begin
            waitEdge();
            #2 checkOutput("stall_hold", 3'b010, 2'b10, 1'b1, 3'b000);
        end
        waitEdge();
        applyStimulus(3'b011, 3'b010, 1'b1);
        #2 checkOutput("stall_release", 3'b010, 2'b10, 1'b1, 3'b010);

        // N wins next; its single flit hands the port to L.
        waitEdge();
        applyStimulus(3'b101, 3'b001, 1'b1);
        #2 checkOutput("after_stall_n", 3'b001, 2'b01, 1'b1, 3'b001);
        waitEdge();
        applyStimulus(3'b101, 3'b000, 1'b1);
        #2 checkOutput("gap_l_flit", 3'b100, 2'b11, 1'b1, 3'b100);
        for (int s = 0; s < 2; s++) begin
            waitEdge();
            applyStimulus(3'b001, 3'b000, 1'b1);
            #2 checkOutput("gap_hold", 3'b100, 2'b11, 1'b1, 3'b000);
        end
        waitEdge();
        applyStimulus(3'b101, 3'b100, 1'b1);
        #2 checkOutput("gap_tail", 3'b100, 2'b11, 1'b1, 3'b100);
        waitEdge();
        applyStimulus(3'b011, 3'b000, 1'b1);
        #2 checkOutput("gap_then_n", 3'b001, 2'b01, 1'b1, 3'b001);

        // Asynchronous reset during N's third flit; pointer must return to N.
        waitEdge();
        #2 checkOutput("rst_flit2", 3'b001, 2'b01, 1'b1, 3'b001);
        waitEdge();
        #2 rst = 1'b0;
        #1 checkOutput("async_rst", 3'b000, 2'b00, 1'b0, 3'b000);
        waitEdge();
        rst = 1'b1;
        waitEdge();
        #2 checkOutput("restart_n", 3'b001, 2'b01, 1'b1, 3'b001);

        // Random traffic with occasional resets, checked by the model.
        for (int c = 0; c < 3000; c++) begin
            waitEdge();
            rst = ($urandom_range(0, 299) != 0);
            applyStimulus({($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                          {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
                          ($urandom_range(0, 3) != 0));
        end

        waitEdge();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_3_arbiter.md
# router_3_arbiter

Output-port arbiter for router 3 of the 2x2 mesh. Three input channels (North, West, Local) compete for one output port. The arbiter grants the port to one input and locks it for a whole packet, from the header flit through the tail flit, then moves on in round-robin order. It sits directly downstream of the flow-control stage: that stage's per-port ready output for this output port drives `ready`. The arbiter's one-hot grant and select drive the crossbar and the input FIFO read enables.

## Interface
- `RESET_PTR`, default 0: round-robin pointer value after reset. 0 = N has highest priority, 1 = W, 2 = L.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Nreq`, `Wreq`, `Lreq`  in  1 each  input channel has a flit at its FIFO head routed to this output (from LBDR).
- `Ntail`, `Wtail`, `Ltail`  in  1 each  the head flit of that channel is a tail flit. Sampled only during a transfer.
- `ready`  in  1  this output may accept a flit this cycle (from flow control).
- `Ngrant`, `Wgrant`, `Lgrant`  out  1 each  registered one-hot grant; at most one high.
- `sel`  out  2  registered crossbar select: 00 none, 01 N, 10 W, 11 L.
- `Nxfer`, `Wxfer`, `Lxfer`  out  1 each  combinational read strobe to the input FIFO: grant & req & ready.
- `busy`  out  1  registered; high whenever a grant is held.

## Operation
- States:
  - IDLE
  - GNT_N
  - GNT_W
  - GNT_L
- Grant and sel decode directly from the state register. Busy = state ≠ IDLE.
- Priority pointer, 2 bits, values 0..2; the value 3 is never reached.
  - Search order is pointer, pointer+1, pointer+2, mod 3.
  - After a grant to port p, the pointer becomes (p+1) mod 3.
- IDLE: if any req is high, enter GNT_x for the first requester in search order. Otherwise stay in IDLE.
- GNT_x: a transfer occurs in any cycle where req_x & ready is high.
  - Transfer with tail_x = 0: stay in GNT_x.
  - Transfer with tail_x = 1: the packet is complete.
    - Re-arbitrate in the same cycle over all current reqs, using the already-updated pointer, and go directly to the winner's GNT state.
    - If no req is high, go to IDLE.
    - The port that just finished may win again only if it is the sole requester.
  - No transfer (req_x low or ready low): stay in GNT_x.
  - The lock is held across req gaps; the grant is never revoked mid-packet.
- Reqs and tails of non-granted ports are ignored except during arbitration.
- Single-flit packets are a header with tail = 1: granted, transferred once, released.

## Timing
- Reset (rst low, asynchronous): state = IDLE, pointer = RESET_PTR, all grants = 0, sel = 00, busy = 0. Xfer outputs are 0 because no grant is held.
- Reset is released synchronously to clk by the integration. The first arbitration happens at the first rising edge with rst high.
- Latency, req to grant: 1 cycle from IDLE. Req asserted in cycle n gives grant in cycle n+1, and the first transfer is possible in cycle n+1 if ready is high.
- Back-to-back packets: a tail transfer in cycle n gives the next grant in cycle n+1, with no bubble cycle.
- Xfer is combinational from req, ready and the registered grant. No path from xfer back into req within the block.
- Reset asserted mid-packet: the grant drops immediately, with no clock needed. The partially sent packet is the system's responsibility.
- ready low while the tail is pending: no transfer and no release. The tail is sent in the first cycle ready returns high.

## Test plan
- Reset values: hold rst low with all reqs high → grants 000, sel 00, busy 0, xfers 0. Release with RESET_PTR=0 → Ngrant = 1 and sel = 01 at the first edge.
- Packet lock: Nreq and Wreq high, N sends a 4-flit packet (tail on flit 4), ready = 1 → Ngrant for exactly 4 transfer cycles, Wgrant in the next cycle, no idle gap.
- Round-robin fairness: all three reqs held high, 1-flit packets → grant sequence N, W, L, N, W, L, one grant per cycle.
- Stall: GNT_W active, ready low for 3 cycles with Wtail = 1 → Wxfer = 0, Wgrant held. Ready goes high → one Wxfer, then release.
- Req gap: GNT_L, Lreq drops for 2 cycles mid-packet while Nreq is high → Lgrant held, Nxfer = 0 throughout. Lreq returns with tail → L completes, then N is granted.
- Async reset mid-packet: in GNT_N after 2 flits, pull rst low between clock edges → Ngrant and busy go low before the next edge. After release → pointer = RESET_PTR and arbitration restarts.
